// File: rtl/regfile_lockable.sv
// Lockable control/status register file on the chip_select bus.
// Holds RW data registers, a key-based lock FSM with wrong-key counting
// and permanent lock, a W1C sticky error bit, a one-cycle pulse register,
// a registered read path and a registered bus-error response.
module regfile_lockable #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 8,
    parameter int                    NUM_DATA_REGS = 4,
    parameter logic [31:0]           LOCK_KEY      = 32'h4C4F434B,
    parameter logic [31:0]           UNLOCK_KEY    = 32'h554E4C4B,
    parameter int                    MAX_FAIL      = 3,
    parameter logic [DATA_WIDTH-1:0] DATA_RST      = {DATA_WIDTH{1'b0}}
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ADDR_WIDTH-1:0]               addr,
    input  logic                                chip_select,
    input  logic                                write_en,
    input  logic                                read_en,
    input  logic [DATA_WIDTH-1:0]               write_data,
    output logic [DATA_WIDTH-1:0]               read_data,
    output logic                                data_valid,
    output logic                                bus_error,
    input  logic                                hw_err_set,
    output logic [1:0]                          lock_state,
    output logic [NUM_DATA_REGS*DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0]               pulse_out
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_PERM     = 2'd2
    } lock_st_e;

    localparam logic [DATA_WIDTH-1:0] LOCK_KEY_C   = DATA_WIDTH'(LOCK_KEY);
    localparam logic [DATA_WIDTH-1:0] UNLOCK_KEY_C = DATA_WIDTH'(UNLOCK_KEY);
    localparam logic [3:0]            MAX_FAIL_C   = 4'(MAX_FAIL);
    localparam logic [ADDR_WIDTH:0]   DATA_LO_C    = (ADDR_WIDTH+1)'(4);
    localparam logic [ADDR_WIDTH:0]   DATA_HI_C    = (ADDR_WIDTH+1)'(4 + NUM_DATA_REGS);

    lock_st_e                state_q, state_d;
    logic [3:0]              fail_cnt_q, fail_cnt_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   data_q [NUM_DATA_REGS];
    logic [DATA_WIDTH-1:0]   data_d [NUM_DATA_REGS];
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    bus_error_q, bus_error_d;
    logic [DATA_WIDTH-1:0]   pulse_q, pulse_d;

    logic                    wr_s, rd_s;
    logic                    sel_lock_s, sel_status_s, sel_pulse_s, sel_data_s;
    logic                    locked_s, perm_s;
    logic                    lock_err_s, acc_err_s;
    logic [3:0]              fail_inc_s;
    logic [DATA_WIDTH-1:0]   status_s;

    assign wr_s         = chip_select & write_en;
    assign rd_s         = chip_select & read_en;
    assign sel_lock_s   = (addr == ADDR_WIDTH'(0));
    assign sel_status_s = (addr == ADDR_WIDTH'(1));
    assign sel_pulse_s  = (addr == ADDR_WIDTH'(2));
    assign sel_data_s   = ({1'b0, addr} >= DATA_LO_C) && ({1'b0, addr} < DATA_HI_C);
    assign fail_inc_s   = fail_cnt_q + 4'd1;

    // Lock FSM state and fail counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNLOCKED;
            fail_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Lock FSM next state: key checks on writes to the LOCK register.
    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        lock_err_s = 1'b0;
        if (wr_s && sel_lock_s) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (write_data == LOCK_KEY_C) begin
                        state_d    = ST_LOCKED;
                        fail_cnt_d = 4'd0;
                    end else begin
                        state_d    = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (write_data == UNLOCK_KEY_C) begin
                        state_d    = ST_UNLOCKED;
                        fail_cnt_d = 4'd0;
                    end else begin
                        fail_cnt_d = fail_inc_s;
                        lock_err_s = 1'b1;
                        if (fail_inc_s == MAX_FAIL_C) begin
                            state_d = ST_PERM;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_PERM: begin
                    lock_err_s = 1'b1;
                end
                default: begin
                    // Unreachable encoding: fall back to the most restrictive state.
                    state_d    = ST_PERM;
                    lock_err_s = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Lock FSM outputs: decoded lock flags and the status word.
    always_comb begin
        locked_s       = (state_q != ST_UNLOCKED);
        perm_s         = (state_q == ST_PERM);
        status_s       = {DATA_WIDTH{1'b0}};
        status_s[0]    = locked_s;
        status_s[1]    = perm_s;
        status_s[2]    = err_q;
        status_s[7:4]  = fail_cnt_q;
    end

    // Register-file datapath: writes, read mux, error detection, pulse.
    always_comb begin
        data_d       = data_q;
        pulse_d      = {DATA_WIDTH{1'b0}};
        read_data_d  = read_data_q;
        data_valid_d = rd_s;
        acc_err_s    = 1'b0;
        if (wr_s) begin
            if (sel_data_s) begin
                if (locked_s) begin
                    acc_err_s = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_DATA_REGS; i++) begin
                        if (addr == ADDR_WIDTH'(i + 4)) begin
                            data_d[i] = write_data;
                        end else begin
                            data_d[i] = data_q[i];
                        end
                    end
                end
            end else if (sel_pulse_s) begin
                if (locked_s) begin
                    acc_err_s = 1'b1;
                end else begin
                    pulse_d = write_data;
                end
            end else if (sel_lock_s || sel_status_s) begin
                acc_err_s = 1'b0;
            end else begin
                acc_err_s = 1'b1;
            end
        end else begin
            acc_err_s = 1'b0;
        end
        if (rd_s) begin
            read_data_d = {DATA_WIDTH{1'b0}};
            if (sel_status_s) begin
                read_data_d = status_s;
            end else if (sel_data_s) begin
                for (int i = 0; i < NUM_DATA_REGS; i++) begin
                    if (addr == ADDR_WIDTH'(i + 4)) begin
                        read_data_d = data_q[i];
                    end else begin
                        read_data_d = read_data_d;
                    end
                end
            end else if (sel_lock_s || sel_pulse_s) begin
                read_data_d = {DATA_WIDTH{1'b0}};
            end else begin
                acc_err_s = 1'b1;
            end
        end else begin
            read_data_d = read_data_q;
        end
    end

    // Sticky error bit: any error or hardware set wins over a W1C clear.
    always_comb begin
        bus_error_d = acc_err_s | lock_err_s;
        if (bus_error_d || hw_err_set) begin
            err_d = 1'b1;
        end else if (wr_s && sel_status_s && write_data[2]) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Datapath registers and registered bus responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DATA_REGS; i++) begin
                data_q[i] <= DATA_RST;
            end
            err_q        <= 1'b0;
            read_data_q  <= {DATA_WIDTH{1'b0}};
            data_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            pulse_q      <= {DATA_WIDTH{1'b0}};
        end else begin
            data_q       <= data_d;
            err_q        <= err_d;
            read_data_q  <= read_data_d;
            data_valid_q <= data_valid_d;
            bus_error_q  <= bus_error_d;
            pulse_q      <= pulse_d;
        end
    end

    for (genvar g = 0; g < NUM_DATA_REGS; g++) begin : g_data_out
        assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end

    assign read_data  = read_data_q;
    assign data_valid = data_valid_q;
    assign bus_error  = bus_error_q;
    assign lock_state = state_q;
    assign pulse_out  = pulse_q;

endmodule

// File: tb/tb_regfile_lockable.sv
// Testbench for regfile_lockable: scenario tasks with inline checks, plus a
// read scoreboard fed when reads are issued and drained on data_valid.
module tb_regfile_lockable;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 4;
    localparam logic [31:0] LOCK_K   = 32'h4C4F434B;
    localparam logic [31:0] UNLOCK_K = 32'h554E4C4B;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AW-1:0]    addr = '0;
    logic             chip_select = 1'b0;
    logic             write_en = 1'b0;
    logic             read_en = 1'b0;
    logic [DW-1:0]    write_data = '0;
    logic [DW-1:0]    read_data;
    logic             data_valid;
    logic             bus_error;
    logic             hw_err_set = 1'b0;
    logic [1:0]       lock_state;
    logic [NR*DW-1:0] data_out;
    logic [DW-1:0]    pulse_out;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_v;

    regfile_lockable #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_DATA_REGS(NR),
        .LOCK_KEY(LOCK_K), .UNLOCK_KEY(UNLOCK_K), .MAX_FAIL(3),
        .DATA_RST(32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .chip_select(chip_select),
        .write_en(write_en), .read_en(read_en), .write_data(write_data),
        .read_data(read_data), .data_valid(data_valid), .bus_error(bus_error),
        .hw_err_set(hw_err_set), .lock_state(lock_state), .data_out(data_out),
        .pulse_out(pulse_out)
    );

    always #5 clk = ~clk;

    // Scoreboard: every data_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst_n && data_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: data_valid=1 read_data=%h, no read outstanding", read_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (read_data !== exp_v) begin
                    bad++;
                    $display("FAIL rd_data: got %h expected %h", read_data, exp_v);
                end
            end
        end
    end

    // One bus cycle; outputs of this access are visible on return.
    task automatic acc(input logic [AW-1:0] a, input logic do_wr, input logic [DW-1:0] wd,
                       input logic do_rd, input logic [DW-1:0] rexp, input logic hw);
        addr = a; chip_select = 1'b1; write_en = do_wr; read_en = do_rd;
        write_data = wd; hw_err_set = hw;
        if (do_rd) exp_q.push_back(rexp);
        @(posedge clk); #1;
        chip_select = 1'b0; write_en = 1'b0; read_en = 1'b0; hw_err_set = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] wd);
        acc(a, 1'b1, wd, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] rexp);
        acc(a, 1'b0, 32'h0, 1'b1, rexp, 1'b0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic chk_berr(input string nm, input logic e);
        total++;
        if (bus_error !== e) begin
            bad++;
            $display("FAIL %s: bus_error=%b expected %b", nm, bus_error, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (lock_state !== 2'd0 || bus_error !== 1'b0 || data_valid !== 1'b0 ||
            read_data !== 32'h0 || pulse_out !== 32'h0 || data_out !== {NR*DW{1'b0}}) begin
            bad++;
            $display("FAIL reset_state: ls=%0d be=%b dv=%b rd=%h po=%h do=%h expected all 0",
                     lock_state, bus_error, data_valid, read_data, pulse_out, data_out);
        end
        @(negedge clk); rst_n = 1'b1;
        idle();
        for (int i = 4; i < 8; i++) begin
            rd(AW'(i), 32'h0);
            chk_berr("reset_rd_noerr", 1'b0);
        end
        idle();
    endtask

    task automatic test_read_old();
        wr(8'h05, 32'h1234);
        acc(8'h05, 1'b1, 32'hBEEF, 1'b1, 32'h1234, 1'b0);
        rd(8'h05, 32'hBEEF);
        total++;
        if (data_out[1*DW +: DW] !== 32'hBEEF) begin
            bad++;
            $display("FAIL data_out1: got %h expected %h", data_out[1*DW +: DW], 32'hBEEF);
        end
        wr(8'h07, 32'h77);
        rd(8'h07, 32'h77);
        idle(); idle();
        total++;
        if (read_data !== 32'h77) begin
            bad++;
            $display("FAIL rd_hold: got %h expected %h", read_data, 32'h77);
        end
        wr(8'h00, 32'h1);
        chk_berr("unlocked_badkey_noerr", 1'b0);
        total++;
        if (lock_state !== 2'd0) begin
            bad++;
            $display("FAIL unlocked_badkey_state: got %0d expected 0", lock_state);
        end
    endtask

    task automatic test_lock();
        wr(8'h00, LOCK_K);
        chk_berr("lock_noerr", 1'b0);
        total++;
        if (lock_state !== 2'd1) begin
            bad++;
            $display("FAIL lock_state: got %0d expected 1", lock_state);
        end
        wr(8'h04, 32'hFFFF);
        chk_berr("locked_wr_err", 1'b1);
        total++;
        if (data_out[0 +: DW] !== 32'h0) begin
            bad++;
            $display("FAIL locked_data: got %h expected 0", data_out[0 +: DW]);
        end
        rd(8'h01, 32'h5);
        chk_berr("status_rd_noerr", 1'b0);
        wr(8'h02, 32'h5A);
        chk_berr("locked_pulse_err", 1'b1);
        total++;
        if (pulse_out !== 32'h0) begin
            bad++;
            $display("FAIL locked_pulse: got %h expected 0", pulse_out);
        end
        wr(8'h00, UNLOCK_K);
        chk_berr("unlock_noerr", 1'b0);
        rd(8'h01, 32'h4);
        wr(8'h01, 32'h4);
        chk_berr("w1c_noerr", 1'b0);
        rd(8'h01, 32'h0);
        idle();
    endtask

    task automatic test_perm();
        wr(8'h05, 32'h55);
        wr(8'h00, LOCK_K);
        wr(8'h00, 32'h1111);
        chk_berr("badkey1_err", 1'b1);
        rd(8'h01, 32'h15);
        wr(8'h00, 32'h2222);
        rd(8'h01, 32'h25);
        wr(8'h00, 32'h3333);
        chk_berr("badkey3_err", 1'b1);
        total++;
        if (lock_state !== 2'd2) begin
            bad++;
            $display("FAIL perm_state: got %0d expected 2", lock_state);
        end
        rd(8'h01, 32'h37);
        wr(8'h00, UNLOCK_K);
        chk_berr("perm_unlock_err", 1'b1);
        total++;
        if (lock_state !== 2'd2) begin
            bad++;
            $display("FAIL perm_stays: got %0d expected 2", lock_state);
        end
        wr(8'h06, 32'h66);
        chk_berr("perm_wr_err", 1'b1);
        idle(); idle();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (lock_state !== 2'd0 || data_out[1*DW +: DW] !== 32'h0 || data_out[2*DW +: DW] !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: ls=%0d d1=%h d2=%h expected 0 0 0",
                     lock_state, data_out[1*DW +: DW], data_out[2*DW +: DW]);
        end
        @(negedge clk); rst_n = 1'b1;
        idle();
        rd(8'h01, 32'h0);
        idle();
    endtask

    task automatic test_back_to_back();
        wr(8'h02, 32'hA5);
        total++;
        if (pulse_out !== 32'hA5) begin
            bad++;
            $display("FAIL pulse1: got %h expected %h", pulse_out, 32'hA5);
        end
        wr(8'h02, 32'hA5);
        total++;
        if (pulse_out !== 32'hA5) begin
            bad++;
            $display("FAIL pulse2: got %h expected %h", pulse_out, 32'hA5);
        end
        idle();
        total++;
        if (pulse_out !== 32'h0) begin
            bad++;
            $display("FAIL pulse_end: got %h expected 0", pulse_out);
        end
        rd(8'h02, 32'h0);
        chk_berr("pulse_rd_noerr", 1'b0);
        idle();
    endtask

    task automatic test_err();
        acc(8'h01, 1'b1, 32'h4, 1'b0, 32'h0, 1'b1);
        chk_berr("hw_set_noerr", 1'b0);
        rd(8'h01, 32'h4);
        wr(8'h01, 32'h4);
        rd(8'h01, 32'h0);
        wr(8'h07, 32'h77);
        rd(8'h07, 32'h77);
        rd(8'hFF, 32'h0);
        chk_berr("unmapped_rd_err", 1'b1);
        rd(8'h03, 32'h0);
        chk_berr("reserved_rd_err", 1'b1);
        wr(8'h08, 32'h88);
        chk_berr("unmapped_wr_err", 1'b1);
        idle();
        chk_berr("err_pulse_end", 1'b0);
        rd(8'h01, 32'h4);
        idle();
    endtask

    initial begin
        test_reset();
        test_read_old();
        test_lock();
        test_perm();
        test_back_to_back();
        test_err();
        idle(); idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_missing: %0d reads without data_valid, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
